// File: rtl/axi_w_router_1x2_pkg.sv
// Shared definitions for the 1x2 W-channel router: select encoding, FSM states
// and the saturating beat counter helper.
package axi_w_router_1x2_pkg;

   localparam logic SEL_M0 = 1'b0;
   localparam logic SEL_M1 = 1'b1;

   localparam int BEAT_CNT_W = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      ROUTE = 1'b1
   } rtr_state_t;

   function automatic logic [BEAT_CNT_W-1:0] sat_inc(input logic [BEAT_CNT_W-1:0] v);
      return (v == '1) ? v : v + BEAT_CNT_W'(1);
   endfunction

endpackage

// File: rtl/axi_w_router_1x2_sync_fifo_1b.sv
// One-bit-wide synchronous FIFO holding slave-select tokens; push while full is
// accepted only when a pop happens in the same cycle.
module sync_fifo_1b
   import axi_w_router_1x2_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   push_data,
   input  logic                   pop,
   output logic                   pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DEPTH-1:0] mem;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   // Pointers are power-of-two wide, so they wrap modulo DEPTH for free.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/axi_w_router_1x2.sv
// W-channel steering stage: pops AW-side select tokens and routes each W burst
// to slave port 0 or 1, holding the select from first beat to WLAST.
module axi_w_router_1x2
   import axi_w_router_1x2_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int SEL_DEPTH  = 4
) (
   input  logic                       ACLK,
   input  logic                       ARESETN,
   input  logic                       aw_sel_valid,
   input  logic                       aw_sel,
   output logic                       aw_sel_ready,
   input  logic [DATA_WIDTH-1:0]      S_WDATA,
   input  logic [STRB_WIDTH-1:0]      S_WSTRB,
   input  logic                       S_WLAST,
   input  logic                       S_WVALID,
   output logic                       S_WREADY,
   output logic [DATA_WIDTH-1:0]      M0_WDATA,
   output logic [STRB_WIDTH-1:0]      M0_WSTRB,
   output logic                       M0_WLAST,
   output logic                       M0_WVALID,
   input  logic                       M0_WREADY,
   output logic [DATA_WIDTH-1:0]      M1_WDATA,
   output logic [STRB_WIDTH-1:0]      M1_WSTRB,
   output logic                       M1_WLAST,
   output logic                       M1_WVALID,
   input  logic                       M1_WREADY,
   output logic [$clog2(SEL_DEPTH):0] sel_count,
   output logic [BEAT_CNT_W-1:0]      beat_cnt,
   output logic                       busy
);

   rtr_state_t state;
   logic       cur_sel;
   logic       fifo_head;
   logic       fifo_full;
   logic       fifo_empty;
   logic       push;
   logic       pop;
   logic       route_en;
   logic       xfer;
   logic       last_xfer;

   sync_fifo_1b #(
      .DEPTH (SEL_DEPTH)
   ) u_sel_fifo (
      .clk       (ACLK),
      .rst_n     (ARESETN),
      .push      (push),
      .push_data (aw_sel),
      .pop       (pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (sel_count)
   );

   assign aw_sel_ready = !fifo_full;
   assign push         = aw_sel_valid && aw_sel_ready;

   // Gating with ARESETN keeps a beat from being accepted in the reset cycle.
   assign route_en  = (state == ROUTE) && ARESETN;
   assign S_WREADY  = route_en && ((cur_sel == SEL_M1) ? M1_WREADY : M0_WREADY);
   assign xfer      = S_WVALID && S_WREADY;
   assign last_xfer = xfer && S_WLAST;
   assign pop       = ((state == IDLE) || last_xfer) && !fifo_empty;

   // Non-selected port is held at zero to match the downstream demux.
   always_comb begin
      M0_WDATA  = '0;
      M0_WSTRB  = '0;
      M0_WLAST  = 1'b0;
      M0_WVALID = 1'b0;
      M1_WDATA  = '0;
      M1_WSTRB  = '0;
      M1_WLAST  = 1'b0;
      M1_WVALID = 1'b0;
      if (route_en) begin
         if (cur_sel == SEL_M1) begin
            M1_WDATA  = S_WDATA;
            M1_WSTRB  = S_WSTRB;
            M1_WLAST  = S_WLAST;
            M1_WVALID = S_WVALID;
         end else begin
            M0_WDATA  = S_WDATA;
            M0_WSTRB  = S_WSTRB;
            M0_WLAST  = S_WLAST;
            M0_WVALID = S_WVALID;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state    <= IDLE;
         cur_sel  <= SEL_M0;
         beat_cnt <= '0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  state    <= ROUTE;
                  busy     <= 1'b1;
                  cur_sel  <= fifo_head;
                  beat_cnt <= '0;
               end
            end
            ROUTE: begin
               if (xfer) begin
                  // A queued token at WLAST chains straight into the next burst.
                  if (S_WLAST && !fifo_empty) begin
                     cur_sel  <= fifo_head;
                     beat_cnt <= '0;
                  end else begin
                     beat_cnt <= sat_inc(beat_cnt);
                     if (S_WLAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_w_router_1x2.sv
// Directed bench for axi_w_router_1x2: reset, single burst, chained bursts,
// backpressure, token FIFO full/wrap and reset mid-burst.
module tb_axi_w_router_1x2;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic        aw_sel_valid;
   logic        aw_sel;
   logic        aw_sel_ready;
   logic [31:0] S_WDATA;
   logic [3:0]  S_WSTRB;
   logic        S_WLAST;
   logic        S_WVALID;
   logic        S_WREADY;
   logic [31:0] M0_WDATA;
   logic [3:0]  M0_WSTRB;
   logic        M0_WLAST;
   logic        M0_WVALID;
   logic        M0_WREADY;
   logic [31:0] M1_WDATA;
   logic [3:0]  M1_WSTRB;
   logic        M1_WLAST;
   logic        M1_WVALID;
   logic        M1_WREADY;
   logic [2:0]  sel_count;
   logic [7:0]  beat_cnt;
   logic        busy;

   int total = 0;
   int bad   = 0;

   axi_w_router_1x2 #(
      .DATA_WIDTH (32),
      .STRB_WIDTH (4),
      .SEL_DEPTH  (4)
   ) dut (
      .ACLK         (ACLK),
      .ARESETN      (ARESETN),
      .aw_sel_valid (aw_sel_valid),
      .aw_sel       (aw_sel),
      .aw_sel_ready (aw_sel_ready),
      .S_WDATA      (S_WDATA),
      .S_WSTRB      (S_WSTRB),
      .S_WLAST      (S_WLAST),
      .S_WVALID     (S_WVALID),
      .S_WREADY     (S_WREADY),
      .M0_WDATA     (M0_WDATA),
      .M0_WSTRB     (M0_WSTRB),
      .M0_WLAST     (M0_WLAST),
      .M0_WVALID    (M0_WVALID),
      .M0_WREADY    (M0_WREADY),
      .M1_WDATA     (M1_WDATA),
      .M1_WSTRB     (M1_WSTRB),
      .M1_WLAST     (M1_WLAST),
      .M1_WVALID    (M1_WVALID),
      .M1_WREADY    (M1_WREADY),
      .sel_count    (sel_count),
      .beat_cnt     (beat_cnt),
      .busy         (busy)
   );

   always #5 ACLK = ~ACLK;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge ACLK);
      #1;
   endtask

   task automatic test_reset();
      ARESETN = 1'b0; aw_sel_valid = 1'b0; aw_sel = 1'b0;
      S_WDATA = '0; S_WSTRB = '0; S_WLAST = 1'b0; S_WVALID = 1'b0;
      M0_WREADY = 1'b0; M1_WREADY = 1'b0;
      repeat (3) cyc();
      ARESETN = 1'b1;
      cyc();
      total++; if (aw_sel_ready !== 1'b1) begin bad++; $display("FAIL reset_aw_ready: got %b want 1", aw_sel_ready); end
      total++; if (S_WREADY !== 1'b0) begin bad++; $display("FAIL reset_s_wready: got %b want 0", S_WREADY); end
      total++; if ({M0_WVALID, M1_WVALID} !== 2'b00) begin bad++; $display("FAIL reset_m_wvalid: got %b want 00", {M0_WVALID, M1_WVALID}); end
      total++; if (sel_count !== 3'd0) begin bad++; $display("FAIL reset_sel_count: got %0d want 0", sel_count); end
      total++; if (busy !== 1'b0 || beat_cnt !== 8'd0) begin bad++; $display("FAIL reset_busy_cnt: got %b/%0d want 0/0", busy, beat_cnt); end
   endtask

   task automatic test_single_burst();
      logic [31:0] d;
      M0_WREADY = 1'b1; M1_WREADY = 1'b1;
      aw_sel_valid = 1'b1; aw_sel = 1'b1;
      cyc();
      aw_sel_valid = 1'b0;
      S_WVALID = 1'b1; S_WDATA = 32'h11111111; S_WSTRB = 4'hF; S_WLAST = 1'b0;
      #1;
      total++; if (sel_count !== 3'd1) begin bad++; $display("FAIL single_token_queued: got %0d want 1", sel_count); end
      total++; if (S_WREADY !== 1'b0 || M1_WVALID !== 1'b0) begin bad++; $display("FAIL single_idle_stall: got %b/%b want 0/0", S_WREADY, M1_WVALID); end
      cyc();
      for (int i = 0; i < 4; i++) begin
         d = 32'h11111111 * (i + 1);
         S_WDATA = d; S_WLAST = (i == 3);
         #1;
         total++; if (M1_WVALID !== 1'b1 || M1_WDATA !== d || M1_WLAST !== (i == 3)) begin bad++; $display("FAIL single_m1_beat%0d: got v=%b d=%h l=%b want v=1 d=%h", i, M1_WVALID, M1_WDATA, M1_WLAST, d); end
         total++; if (M0_WDATA !== 32'h0 || M0_WVALID !== 1'b0) begin bad++; $display("FAIL single_m0_zero%0d: got d=%h v=%b want 0", i, M0_WDATA, M0_WVALID); end
         total++; if (S_WREADY !== 1'b1 || beat_cnt !== 8'(i)) begin bad++; $display("FAIL single_ready_cnt%0d: got %b/%0d want 1/%0d", i, S_WREADY, beat_cnt, i); end
         cyc();
      end
      S_WVALID = 1'b0; S_WLAST = 1'b0;
      #1;
      total++; if (beat_cnt !== 8'd4) begin bad++; $display("FAIL single_beat_cnt: got %0d want 4", beat_cnt); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_back_idle: got busy=%b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      logic [2:0]  sels;
      logic [31:0] d;
      logic        s;
      sels = 3'b010;
      for (int i = 0; i < 3; i++) begin
         aw_sel_valid = 1'b1; aw_sel = sels[i];
         cyc();
      end
      aw_sel_valid = 1'b0;
      for (int j = 0; j < 6; j++) begin
         s = sels[j/2];
         d = 32'hB0000000 + 32'(j);
         S_WVALID = 1'b1; S_WDATA = d; S_WLAST = (j % 2 == 1);
         #1;
         if (s) begin
            total++; if (M1_WVALID !== 1'b1 || M1_WDATA !== d || M0_WVALID !== 1'b0) begin bad++; $display("FAIL b2b_beat%0d: got m1v=%b m1d=%h m0v=%b want 1/%h/0", j, M1_WVALID, M1_WDATA, M0_WVALID, d); end
         end else begin
            total++; if (M0_WVALID !== 1'b1 || M0_WDATA !== d || M1_WVALID !== 1'b0) begin bad++; $display("FAIL b2b_beat%0d: got m0v=%b m0d=%h m1v=%b want 1/%h/0", j, M0_WVALID, M0_WDATA, M1_WVALID, d); end
         end
         total++; if (S_WREADY !== 1'b1) begin bad++; $display("FAIL b2b_no_bubble%0d: got S_WREADY=%b want 1", j, S_WREADY); end
         cyc();
      end
      S_WVALID = 1'b0; S_WLAST = 1'b0;
      #1;
      total++; if (busy !== 1'b0 || sel_count !== 3'd0) begin bad++; $display("FAIL b2b_end: got busy=%b cnt=%0d want 0/0", busy, sel_count); end
   endtask

   task automatic test_backpressure();
      M0_WREADY = 1'b0; M1_WREADY = 1'b1;
      aw_sel_valid = 1'b1; aw_sel = 1'b0;
      cyc();
      aw_sel_valid = 1'b0;
      cyc();
      S_WVALID = 1'b1; S_WDATA = 32'hAAAAAAAA; S_WLAST = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (S_WREADY !== 1'b0) begin bad++; $display("FAIL bp_stall%0d: got S_WREADY=%b want 0", i, S_WREADY); end
         total++; if (M0_WDATA !== 32'hAAAAAAAA || M0_WVALID !== 1'b1 || M1_WVALID !== 1'b0) begin bad++; $display("FAIL bp_hold%0d: got d=%h v=%b m1v=%b want AAAAAAAA/1/0", i, M0_WDATA, M0_WVALID, M1_WVALID); end
         cyc();
      end
      total++; if (beat_cnt !== 8'd0 || busy !== 1'b1) begin bad++; $display("FAIL bp_no_xfer: got cnt=%0d busy=%b want 0/1", beat_cnt, busy); end
      M0_WREADY = 1'b1;
      #1;
      total++; if (S_WREADY !== 1'b1) begin bad++; $display("FAIL bp_release: got S_WREADY=%b want 1", S_WREADY); end
      cyc();
      S_WVALID = 1'b0; S_WLAST = 1'b0;
      #1;
      total++; if (beat_cnt !== 8'd1 || busy !== 1'b0) begin bad++; $display("FAIL bp_done: got cnt=%0d busy=%b want 1/0", beat_cnt, busy); end
   endtask

   task automatic test_fifo_wrap();
      logic [4:0]  fill;
      logic [6:0]  order;
      logic [31:0] d;
      logic        s;
      fill  = 5'b01101;
      order = 7'b1001101;
      M0_WREADY = 1'b1; M1_WREADY = 1'b1;
      for (int i = 0; i < 5; i++) begin
         aw_sel_valid = 1'b1; aw_sel = fill[i];
         cyc();
      end
      aw_sel_valid = 1'b0;
      #1;
      total++; if (sel_count !== 3'd4 || aw_sel_ready !== 1'b0) begin bad++; $display("FAIL wrap_full: got cnt=%0d rdy=%b want 4/0", sel_count, aw_sel_ready); end
      aw_sel_valid = 1'b1; aw_sel = 1'b1;
      cyc();
      aw_sel_valid = 1'b0;
      #1;
      total++; if (sel_count !== 3'd4) begin bad++; $display("FAIL wrap_5th_ignored: got cnt=%0d want 4", sel_count); end
      for (int k = 0; k < 7; k++) begin
         s = order[k];
         d = 32'hC0000000 + 32'(k);
         aw_sel_valid = (k == 1 || k == 2); aw_sel = (k == 2);
         S_WVALID = 1'b1; S_WDATA = d; S_WLAST = 1'b1;
         #1;
         if (s) begin
            total++; if (M1_WVALID !== 1'b1 || M1_WDATA !== d || M0_WVALID !== 1'b0) begin bad++; $display("FAIL wrap_order%0d: got m1v=%b m0v=%b want port 1", k, M1_WVALID, M0_WVALID); end
         end else begin
            total++; if (M0_WVALID !== 1'b1 || M0_WDATA !== d || M1_WVALID !== 1'b0) begin bad++; $display("FAIL wrap_order%0d: got m0v=%b m1v=%b want port 0", k, M0_WVALID, M1_WVALID); end
         end
         cyc();
      end
      aw_sel_valid = 1'b0; S_WVALID = 1'b0; S_WLAST = 1'b0;
      #1;
      total++; if (sel_count !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL wrap_drained: got cnt=%0d busy=%b want 0/0", sel_count, busy); end
   endtask

   task automatic test_reset_mid_burst();
      logic [2:0] toks;
      toks = 3'b001;
      M0_WREADY = 1'b1; M1_WREADY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         aw_sel_valid = 1'b1; aw_sel = toks[i];
         cyc();
      end
      aw_sel_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         S_WVALID = 1'b1; S_WDATA = 32'hD0000000 + 32'(i); S_WLAST = 1'b0;
         #1;
         total++; if (M1_WVALID !== 1'b1 || S_WREADY !== 1'b1) begin bad++; $display("FAIL rmid_beat%0d: got m1v=%b rdy=%b want 1/1", i, M1_WVALID, S_WREADY); end
         cyc();
      end
      total++; if (sel_count !== 3'd2 || beat_cnt !== 8'd2) begin bad++; $display("FAIL rmid_pre: got cnt=%0d beats=%0d want 2/2", sel_count, beat_cnt); end
      S_WDATA = 32'hD0000002;
      ARESETN = 1'b0;
      #1;
      total++; if (S_WREADY !== 1'b0 || M1_WVALID !== 1'b0 || M1_WDATA !== 32'h0) begin bad++; $display("FAIL rmid_no_fwd: got rdy=%b v=%b d=%h want 0/0/0", S_WREADY, M1_WVALID, M1_WDATA); end
      cyc();
      ARESETN = 1'b1;
      #1;
      total++; if (sel_count !== 3'd0 || busy !== 1'b0 || beat_cnt !== 8'd0) begin bad++; $display("FAIL rmid_state: got cnt=%0d busy=%b beats=%0d want 0/0/0", sel_count, busy, beat_cnt); end
      total++; if ({M0_WVALID, M1_WVALID, M0_WDATA, M1_WDATA} !== '0 || aw_sel_ready !== 1'b1) begin bad++; $display("FAIL rmid_outputs: got v=%b%b d0=%h d1=%h rdy=%b want zeros/1", M0_WVALID, M1_WVALID, M0_WDATA, M1_WDATA, aw_sel_ready); end
      for (int i = 0; i < 2; i++) begin
         cyc();
         total++; if (S_WREADY !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_stall%0d: got rdy=%b busy=%b want 0/0", i, S_WREADY, busy); end
      end
      S_WVALID = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_back_to_back();
      test_backpressure();
      test_fifo_wrap();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
